endec_frame_rx: RTL and testbench
=================================

ENDEC_FRAME_RX -- requirements
Module: endec_frame_rx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 128, decoded bits per frame (one channel symbol per decoded bit).
REQ-002 SHALL have parameter MAX_RATE, default 3, maximum coded bits per channel symbol.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, decode watchdog limit; used only when ENDEC_RX_TIMEOUT_EN is defined.
REQ-004 SHALL have port sys_clk, input, 1, single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, global enable; low freezes all state.
REQ-007 SHALL have port i_code_rate, input, 1, 0 = rate 1/2, 1 = rate 1/3.
REQ-008 SHALL have port i_sym_valid, input, 1, channel symbol valid.
REQ-009 SHALL have port i_sym, input, MAX_RATE, coded symbol; rate 1/2 uses bits [1:0], and bit 2 is ignored.
REQ-010 SHALL have port o_sym_ready, output, 1, symbol accept.
REQ-011 SHALL have port o_dec_frame, output, FRAME_BITS*MAX_RATE, assembled frame to the decoder.
REQ-012 SHALL have port o_dec_start, output, 1, one-cycle decode request.
REQ-013 SHALL have port i_dec_done, input, 1, decoder completion level.
REQ-014 SHALL have port i_dec_data, input, FRAME_BITS, decoded data.
REQ-015 SHALL have port o_data, output, FRAME_BITS, held decoded frame.
REQ-016 SHALL have port o_data_valid, output, 1, decoded frame available.
REQ-017 SHALL have port i_data_ready, input, 1, downstream accept.
REQ-018 SHALL have port o_error, output, 1, one-cycle timeout flag.

Function
REQ-019 SHALL implement states IDLE, COLLECT, DECODE and OUTPUT.
REQ-020 Symbol transfer SHALL occur on a cycle with i_sym_valid && o_sym_ready && en.
REQ-021 o_sym_ready SHALL be high only in IDLE or COLLECT while en is high.
REQ-022 i_code_rate SHALL be latched on the first accepted symbol of a frame and held constant for that frame.
REQ-023 Symbol n (0..FRAME_BITS-1) SHALL be written to o_dec_frame[n*R +: R], where R is 2 or 3 per the latched rate.
REQ-024 For rate 1/2, o_dec_frame bits above 2*FRAME_BITS-1 SHALL read 0.
REQ-025 The 7-bit symbol counter SHALL advance per accepted symbol; IDLE SHALL go to COLLECT on the first accepted symbol.
REQ-026 If the last symbol is accepted in cycle t, o_dec_start SHALL be high for exactly cycle t+1, with the FSM in DECODE.
REQ-027 o_dec_frame SHALL stay stable from that last acceptance until the FSM returns to IDLE.
REQ-028 If i_dec_done is sampled high in DECODE in cycle d, i_dec_data SHALL be captured to o_data and o_data_valid SHALL rise in cycle d+1.
REQ-029 i_dec_done SHALL be ignored outside DECODE.
REQ-030 o_data_valid SHALL stay high, with o_data stable, until i_data_ready is sampled high.
REQ-031 After that handshake the FSM SHALL be in IDLE the next cycle, with the counter at 0 and o_data_valid at 0.
REQ-032 While en is low, no counter, register or state SHALL change, and o_dec_start SHALL not assert.

Reset
REQ-033 Asserting rst low SHALL immediately force IDLE, counter 0, o_dec_frame 0, o_data 0, and o_dec_start, o_data_valid and o_error all 0.
REQ-034 Reset asserted mid-frame or mid-decode SHALL discard the partial frame, and no output pulse SHALL follow.

Configuration
REQ-035 With ENDEC_RX_TIMEOUT_EN defined, a DECODE cycle counter SHALL pulse o_error for one cycle after TIMEOUT_CYCLES cycles with no i_dec_done, and the FSM SHALL return to IDLE with the frame discarded.
REQ-036 Without ENDEC_RX_TIMEOUT_EN, DECODE SHALL wait indefinitely, o_error SHALL be tied 0, and no watchdog logic SHALL be present.

Structure
REQ-037 The FSM state enum, the rate encodings and FRAME_BITS/MAX_RATE defaults SHALL live in the shared endec package alongside the existing CODE_RATE/CONSTR_LEN definitions.
REQ-038 One sub-module, endec_sym_packer, SHALL handle rate-dependent symbol placement into the frame register; the FSM stays in the top module.

Verification
REQ-039 The bench SHALL cover: rate 1/3, 128 symbols of 3'b101 back-to-back -> o_dec_frame equals 128 repeats of 101 and o_dec_start is high one cycle after the last accept.
REQ-040 The bench SHALL cover: rate 1/2, 128 symbols of 3'b110 -> bits [255:0] hold repeats of 10 and bits [383:256] are 0.
REQ-041 The bench SHALL cover: i_dec_done high with i_dec_data=128'hA5A5... and i_data_ready held low for 10 cycles -> o_data_valid stays high with o_data stable, then IDLE one cycle after ready.
REQ-042 The bench SHALL cover: rst pulsed low after symbol 60 -> all outputs 0 at once, and a following full frame decodes normally.
REQ-043 The bench SHALL cover: en low for 5 cycles mid-collect -> counter frozen and o_sym_ready low, with the frame still correct after resume.
REQ-044 The bench SHALL cover, with ENDEC_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16: no i_dec_done -> o_error pulses once, FSM returns to IDLE, and o_data_valid never asserts.

Source files
------------

// File: rtl/endec_pkg.sv
// Shared endec package: code definitions, frame receiver defaults, rate
// encodings and receive FSM state encodings.
package endec_pkg;

  // Convolutional code definitions used across the endec blocks
  localparam int unsigned CODE_RATE      = 2;
  localparam int unsigned CONSTR_LEN     = 7;

  // Frame receiver defaults
  localparam int unsigned FRAME_BITS_DEF = 128;
  localparam int unsigned MAX_RATE_DEF   = 3;

  // Rate select encodings and coded bits per symbol for each rate
  localparam logic        RATE_1_2       = 1'b0;
  localparam logic        RATE_1_3       = 1'b1;
  localparam int unsigned RATE_1_2_BITS  = 2;
  localparam int unsigned RATE_1_3_BITS  = 3;

  // Receive FSM states
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t ST_IDLE    = 2'd0;
  localparam rx_state_t ST_COLLECT = 2'd1;
  localparam rx_state_t ST_DECODE  = 2'd2;
  localparam rx_state_t ST_OUTPUT  = 2'd3;

endpackage

// File: rtl/endec_sym_packer.sv
// Places accepted channel symbols into the frame register at a
// rate-dependent offset (2 or 3 bits per symbol).
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   en           - global enable; low holds the frame
//   first        - first symbol of a frame: clear the frame before writing
//   flush        - discard the frame (clear, no write)
//   wr           - write sym at position idx
//   rate         - rate for this write (RATE_1_2 / RATE_1_3)
//   idx          - symbol index within the frame
//   sym          - coded symbol
//   frame        - assembled frame register
module endec_sym_packer
  import endec_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter int unsigned MAX_RATE   = MAX_RATE_DEF,
  parameter int unsigned IDX_W      = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           first,
  input  logic                           flush,
  input  logic                           wr,
  input  logic                           rate,
  input  logic [IDX_W-1:0]               idx,
  input  logic [MAX_RATE-1:0]            sym,
  output logic [FRAME_BITS*MAX_RATE-1:0] frame
);

  localparam int unsigned FW = FRAME_BITS * MAX_RATE;

  logic [FW-1:0] frame_q;
  logic [FW-1:0] frame_d;

  // Clearing on the first symbol keeps rate-1/2 frames zero above 2*FRAME_BITS
  always_comb begin
    frame_d = (first || flush) ? '0 : frame_q;
    if (wr) begin
      if (rate == RATE_1_3) begin
        frame_d[32'(idx) * RATE_1_3_BITS +: RATE_1_3_BITS] = sym[RATE_1_3_BITS-1:0];
      end else begin
        frame_d[32'(idx) * RATE_1_2_BITS +: RATE_1_2_BITS] = sym[RATE_1_2_BITS-1:0];
      end
    end
  end

  // Frame register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (en) begin
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/endec_frame_rx.sv
// Frame receiver: collects FRAME_BITS coded channel symbols into a frame,
// requests a decode, and holds the decoded frame until downstream accepts.
// Optional decode watchdog enabled by defining ENDEC_RX_TIMEOUT_EN.
// Ports:
//   sys_clk, rst     - clock, async active-low reset
//   en               - global enable; low freezes all state
//   i_code_rate      - 0 = rate 1/2, 1 = rate 1/3 (latched per frame)
//   i_sym_valid/i_sym/o_sym_ready - symbol input handshake
//   o_dec_frame      - assembled coded frame to the decoder
//   o_dec_start      - one-cycle decode request
//   i_dec_done/i_dec_data - decoder completion and result
//   o_data/o_data_valid/i_data_ready - decoded frame output handshake
//   o_error          - one-cycle decode timeout flag (0 without watchdog)
module endec_frame_rx
  import endec_pkg::*;
#(
  parameter int unsigned FRAME_BITS     = FRAME_BITS_DEF,
  parameter int unsigned MAX_RATE       = MAX_RATE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           i_code_rate,
  input  logic                           i_sym_valid,
  input  logic [MAX_RATE-1:0]            i_sym,
  output logic                           o_sym_ready,
  output logic [FRAME_BITS*MAX_RATE-1:0] o_dec_frame,
  output logic                           o_dec_start,
  input  logic                           i_dec_done,
  input  logic [FRAME_BITS-1:0]          i_dec_data,
  output logic [FRAME_BITS-1:0]          o_data,
  output logic                           o_data_valid,
  input  logic                           i_data_ready,
  output logic                           o_error
);

  localparam int unsigned CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  // Elaboration-time parameter sanity
  if (MAX_RATE < RATE_1_3_BITS || FRAME_BITS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("endec_frame_rx: illegal parameter combination");
  end

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rate_q, rate_d;
  logic                  start_q, start_d;
  logic                  valid_q, valid_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  flush;

  logic                  accept;
  logic                  first_sym;
  logic                  last_sym;
  logic                  rate_eff;

`ifdef ENDEC_RX_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
  logic             timeout;

  assign timeout = (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
`endif

  assign o_sym_ready = en && ((state_q == ST_IDLE) || (state_q == ST_COLLECT));
  assign accept      = i_sym_valid && o_sym_ready;
  assign first_sym   = accept && (state_q == ST_IDLE);
  assign last_sym    = (cnt_q == CNT_W'(FRAME_BITS - 1));
  // The first symbol is placed with the live rate; later ones use the latch
  assign rate_eff    = (state_q == ST_IDLE) ? i_code_rate : rate_q;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    start_d = start_q;
    valid_d = valid_q;
    data_d  = data_q;
    flush   = 1'b0;
`ifdef ENDEC_RX_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = err_q;
`endif
    if (en) begin
      start_d = 1'b0;
`ifdef ENDEC_RX_TIMEOUT_EN
      err_d   = 1'b0;
      tmr_d   = '0;
`endif
      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (accept) begin
            if (state_q == ST_IDLE) rate_d = i_code_rate;
            if (last_sym) begin
              cnt_d   = '0;
              start_d = 1'b1;
              state_d = ST_DECODE;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = ST_COLLECT;
            end
          end
        end
        ST_DECODE: begin
          if (i_dec_done) begin
            data_d  = i_dec_data;
            valid_d = 1'b1;
            state_d = ST_OUTPUT;
`ifdef ENDEC_RX_TIMEOUT_EN
          end else if (timeout) begin
            err_d   = 1'b1;
            flush   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmr_d   = tmr_q + TMR_W'(1);
`endif
          end
        end
        ST_OUTPUT: begin
          if (i_data_ready) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and control registers
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rate_q  <= RATE_1_2;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      start_q <= start_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`ifdef ENDEC_RX_TIMEOUT_EN
  // Decode watchdog registers
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end

  assign o_error = err_q & en;
`else
  assign o_error = 1'b0;
`endif

  // Pulses are held across disabled cycles and shown only while enabled,
  // so they last exactly one enabled cycle and never appear with en low
  assign o_dec_start  = start_q & en;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;

  endec_sym_packer #(
    .FRAME_BITS (FRAME_BITS),
    .MAX_RATE   (MAX_RATE),
    .IDX_W      (CNT_W)
  ) u_packer (
    .clk   (sys_clk),
    .rst_n (rst),
    .en    (en),
    .first (first_sym),
    .flush (flush),
    .wr    (accept),
    .rate  (rate_eff),
    .idx   (cnt_q),
    .sym   (i_sym),
    .frame (o_dec_frame)
  );

endmodule

// File: tb/tb_endec_frame_rx.sv
// Self-checking bench for endec_frame_rx (scoreboard of expected frames and
// decoded data). Define ENDEC_RX_TIMEOUT_EN to exercise the watchdog.
module tb_endec_frame_rx;
  import endec_pkg::*;

  localparam int unsigned FB = 128;
  localparam int unsigned MR = 3;
  localparam int unsigned FW = FB * MR;
  localparam int unsigned TO = 16;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          i_code_rate = 1'b0;
  logic          i_sym_valid = 1'b0;
  logic [MR-1:0] i_sym = '0;
  logic          o_sym_ready;
  logic [FW-1:0] o_dec_frame;
  logic          o_dec_start;
  logic          i_dec_done = 1'b0;
  logic [FB-1:0] i_dec_data = '0;
  logic [FB-1:0] o_data;
  logic          o_data_valid;
  logic          i_data_ready = 1'b0;
  logic          o_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [FW-1:0] frame_sb[$];
  logic [FB-1:0] data_sb[$];

  endec_frame_rx #(
    .FRAME_BITS     (FB),
    .MAX_RATE       (MR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .en           (en),
    .i_code_rate  (i_code_rate),
    .i_sym_valid  (i_sym_valid),
    .i_sym        (i_sym),
    .o_sym_ready  (o_sym_ready),
    .o_dec_frame  (o_dec_frame),
    .o_dec_start  (o_dec_start),
    .i_dec_done   (i_dec_done),
    .i_dec_data   (i_dec_data),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_error      (o_error)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Drive nsym symbols; i_code_rate toggles after the first symbol to prove
  // the rate is latched. Optional 5-cycle en-low pause before symbol pause_at.
  task automatic feed(input logic rate, input logic [2:0] pat, input bit rnd,
                      input int nsym, input int pause_at, output logic [FW-1:0] expf);
    logic [2:0] s;
    expf = '0;
    for (int n = 0; n < nsym; n++) begin
      s = rnd ? 3'($urandom_range(0, 7)) : pat;
      if (n == pause_at) begin
        en          = 1'b0;
        i_sym_valid = 1'b1;
        i_sym       = s;
        for (int k = 0; k < 5; k++) begin
          tick();
          n_cmp++;
          if (o_sym_ready !== 1'b0 || o_dec_start !== 1'b0 || o_dec_frame !== expf) begin
            n_bad++;
            $display("FAIL pause_freeze: cycle %0d ready=%b start=%b frame_ok=%b, required ready=0 start=0 frame unchanged",
                     k, o_sym_ready, o_dec_start, (o_dec_frame === expf));
          end
        end
        n_cmp++;
        if (dut.cnt_q !== 7'(pause_at)) begin
          n_bad++;
          $display("FAIL pause_counter: got %0d required %0d", dut.cnt_q, pause_at);
        end
        en = 1'b1;
      end
      i_sym_valid = 1'b1;
      i_sym       = s;
      i_code_rate = (n == 0) ? rate : ~rate;
      if (rate) expf[n*3 +: 3] = s;
      else      expf[n*2 +: 2] = s[1:0];
      tick();
    end
    i_sym_valid = 1'b0;
    i_code_rate = rate;
  endtask

  // Decoder answers after a short latency; downstream accepts at once
  task automatic finish_decode(input logic [FB-1:0] d);
    logic [FB-1:0] exp_d;
    repeat (2) tick();
    i_dec_done = 1'b1;
    i_dec_data = d;
    data_sb.push_back(d);
    tick();
    i_dec_done = 1'b0;
    i_dec_data = '0;
    exp_d = data_sb.pop_front();
    n_cmp++;
    if (o_data_valid !== 1'b1 || o_data !== exp_d) begin
      n_bad++;
      $display("FAIL decode_capture: valid=%b data=%h required valid=1 data=%h", o_data_valid, o_data, exp_d);
    end
    i_data_ready = 1'b1;
    tick();
    i_data_ready = 1'b0;
    n_cmp++;
    if (o_data_valid !== 1'b0 || o_sym_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_after_ready: valid=%b ready=%b required valid=0 ready=1", o_data_valid, o_sym_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (o_dec_frame !== '0 || o_data !== '0 || o_dec_start !== 1'b0 ||
        o_data_valid !== 1'b0 || o_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: frame0=%b data=%h start=%b valid=%b err=%b required all 0",
               (o_dec_frame === '0), o_data, o_dec_start, o_data_valid, o_error);
    end
    en = 1'b1;
    @(negedge sys_clk);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (o_sym_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_idle_ready: got %b required 1", o_sym_ready);
    end
  endtask

  task automatic test_done_ignored();
    i_dec_done = 1'b1;
    i_dec_data = '1;
    repeat (2) tick();
    i_dec_done = 1'b0;
    i_dec_data = '0;
    n_cmp++;
    if (o_data_valid !== 1'b0 || o_data !== '0) begin
      n_bad++;
      $display("FAIL done_outside_decode: valid=%b data=%h required valid=0 data=0", o_data_valid, o_data);
    end
  endtask

  task automatic test_rate13();
    logic [FW-1:0] ef, exp_f, cst;
    feed(RATE_1_3, 3'b101, 1'b0, FB, -1, ef);
    frame_sb.push_back(ef);
    cst = {FB{3'b101}};
    n_cmp++;
    if (o_dec_start !== 1'b1 || o_sym_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL r13_start: start=%b ready=%b required start=1 ready=0", o_dec_start, o_sym_ready);
    end
    exp_f = frame_sb.pop_front();
    n_cmp++;
    if (o_dec_frame !== exp_f || o_dec_frame !== cst) begin
      n_bad++;
      $display("FAIL r13_frame: got %h required %h", o_dec_frame, cst);
    end
    tick();
    n_cmp++;
    if (o_dec_start !== 1'b0) begin
      n_bad++;
      $display("FAIL r13_start_width: got %b required 0", o_dec_start);
    end
    finish_decode({4{32'($urandom)}});
  endtask

  task automatic test_rate12();
    logic [FW-1:0] ef, exp_f, cst;
    feed(RATE_1_2, 3'b110, 1'b0, FB, -1, ef);
    frame_sb.push_back(ef);
    cst = '0;
    cst[2*FB-1:0] = {FB{2'b10}};
    n_cmp++;
    if (o_dec_start !== 1'b1) begin
      n_bad++;
      $display("FAIL r12_start: got %b required 1", o_dec_start);
    end
    exp_f = frame_sb.pop_front();
    n_cmp++;
    if (o_dec_frame !== exp_f || o_dec_frame !== cst) begin
      n_bad++;
      $display("FAIL r12_frame: got %h required %h", o_dec_frame, cst);
    end
    finish_decode({4{32'($urandom)}});
  endtask

  task automatic test_hold_output();
    logic [FW-1:0] ef, exp_f;
    logic [FB-1:0] exp_d;
    feed(RATE_1_3, 3'b000, 1'b1, FB, -1, ef);
    frame_sb.push_back(ef);
    exp_f = frame_sb.pop_front();
    n_cmp++;
    if (o_dec_start !== 1'b1 || o_dec_frame !== exp_f) begin
      n_bad++;
      $display("FAIL hold_frame: start=%b frame=%h required start=1 frame=%h", o_dec_start, o_dec_frame, exp_f);
    end
    repeat (3) tick();
    i_dec_done = 1'b1;
    i_dec_data = {16{8'hA5}};
    data_sb.push_back({16{8'hA5}});
    tick();
    i_dec_done = 1'b0;
    i_dec_data = {16{8'h5A}};
    exp_d = data_sb.pop_front();
    n_cmp++;
    if (o_data_valid !== 1'b1 || o_data !== exp_d) begin
      n_bad++;
      $display("FAIL hold_capture: valid=%b data=%h required valid=1 data=%h", o_data_valid, o_data, exp_d);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++;
      if (o_data_valid !== 1'b1 || o_data !== exp_d || o_dec_frame !== exp_f || o_sym_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable: cycle %0d valid=%b data=%h ready=%b required valid=1 data=%h ready=0",
                 k, o_data_valid, o_data, o_sym_ready, exp_d);
      end
    end
    i_data_ready = 1'b1;
    tick();
    i_data_ready = 1'b0;
    i_dec_data   = '0;
    n_cmp++;
    if (o_data_valid !== 1'b0 || o_sym_ready !== 1'b1 || dut.cnt_q !== 7'd0) begin
      n_bad++;
      $display("FAIL hold_release: valid=%b ready=%b cnt=%0d required valid=0 ready=1 cnt=0",
               o_data_valid, o_sym_ready, dut.cnt_q);
    end
  endtask

  task automatic test_pause();
    logic [FW-1:0] ef, exp_f;
    feed(RATE_1_3, 3'b000, 1'b1, FB, 40, ef);
    frame_sb.push_back(ef);
    exp_f = frame_sb.pop_front();
    n_cmp++;
    if (o_dec_start !== 1'b1 || o_dec_frame !== exp_f) begin
      n_bad++;
      $display("FAIL pause_frame: start=%b frame=%h required start=1 frame=%h", o_dec_start, o_dec_frame, exp_f);
    end
    finish_decode({4{32'($urandom)}});
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] ef, exp_f;
    int bad_pulse;
    feed(RATE_1_3, 3'b011, 1'b0, 61, -1, ef);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (o_dec_frame !== '0 || o_data !== '0 || o_dec_start !== 1'b0 ||
        o_data_valid !== 1'b0 || o_error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: frame0=%b data=%h start=%b valid=%b err=%b required all 0",
               (o_dec_frame === '0), o_data, o_dec_start, o_data_valid, o_error);
    end
    tick();
    @(negedge sys_clk);
    rst = 1'b1;
    bad_pulse = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_dec_start !== 1'b0 || o_data_valid !== 1'b0 || o_sym_ready !== 1'b1) bad_pulse++;
    end
    n_cmp++;
    if (bad_pulse != 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: %0d bad cycles required 0", bad_pulse);
    end
    feed(RATE_1_2, 3'b000, 1'b1, FB, -1, ef);
    frame_sb.push_back(ef);
    exp_f = frame_sb.pop_front();
    n_cmp++;
    if (o_dec_start !== 1'b1 || o_dec_frame !== exp_f) begin
      n_bad++;
      $display("FAIL reset_mid_refill: start=%b frame=%h required start=1 frame=%h", o_dec_start, o_dec_frame, exp_f);
    end
    finish_decode({4{32'($urandom)}});
  endtask

  task automatic test_timeout();
    logic [FW-1:0] ef, exp_f;
    feed(RATE_1_3, 3'b000, 1'b1, FB, -1, ef);
    frame_sb.push_back(ef);
    exp_f = frame_sb.pop_front();
    n_cmp++;
    if (o_dec_start !== 1'b1 || o_dec_frame !== exp_f) begin
      n_bad++;
      $display("FAIL to_frame: start=%b required 1, frame match=%b", o_dec_start, (o_dec_frame === exp_f));
    end
`ifdef ENDEC_RX_TIMEOUT_EN
    begin
      int lat, errs, vals;
      lat = -1; errs = 0; vals = 0;
      for (int c = 1; c <= 60; c++) begin
        tick();
        if (o_error === 1'b1) begin
          errs++;
          if (lat < 0) lat = c;
        end
        if (o_data_valid !== 1'b0) vals++;
      end
      n_cmp++;
      if (lat != int'(TO) || errs != 1) begin
        n_bad++;
        $display("FAIL to_error_pulse: latency=%0d pulses=%0d required latency=%0d pulses=1", lat, errs, TO);
      end
      n_cmp++;
      if (vals != 0 || o_sym_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL to_idle: valid cycles=%0d ready=%b required 0 and ready=1", vals, o_sym_ready);
      end
    end
`else
    begin
      int errs, rdy;
      errs = 0; rdy = 0;
      for (int c = 0; c < 50; c++) begin
        tick();
        if (o_error !== 1'b0) errs++;
        if (o_sym_ready !== 1'b0 || o_data_valid !== 1'b0) rdy++;
      end
      n_cmp++;
      if (errs != 0 || rdy != 0) begin
        n_bad++;
        $display("FAIL decode_wait: error cycles=%0d left-decode cycles=%0d required 0 and 0", errs, rdy);
      end
      finish_decode({4{32'($urandom)}});
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] ef, exp_f;
    for (int f = 0; f < 2; f++) begin
      feed(1'(f), 3'b000, 1'b1, FB, -1, ef);
      frame_sb.push_back(ef);
      exp_f = frame_sb.pop_front();
      n_cmp++;
      if (o_dec_start !== 1'b1 || o_dec_frame !== exp_f) begin
        n_bad++;
        $display("FAIL b2b_frame%0d: start=%b frame=%h required start=1 frame=%h", f, o_dec_start, o_dec_frame, exp_f);
      end
      finish_decode({4{32'($urandom)}});
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    test_reset();
    test_done_ignored();
    test_rate13();
    test_rate12();
    test_hold_output();
    test_pause();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    n_cmp++;
    if (frame_sb.size() != 0 || data_sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: frames=%0d data=%0d left, required 0", frame_sb.size(), data_sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
